// File: rtl/lsu_mem_req.sv
// Load/store initiator: turns B/H/W/D requests into 8-byte-aligned memory beats and returns extended load data.
// Build option: define LSU_SPLIT_MISALIGN_EN to split 8-byte-boundary-crossing accesses into two beats.
module lsu_mem_req (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned XLEN  = 64;
   localparam int unsigned LANES = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BEAT0 = 2'd1,
      S_BEAT1 = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
`ifdef LSU_SPLIT_MISALIGN_EN
   logic [XLEN-1:0]   lo_q, lo_d;
`endif

   logic [2:0]        off;
   logic [LANES-1:0]  nmask;
   logic              beat0;
   logic [XLEN-1:0]   base;

   // True when the access spills past the end of its 8-byte beat.
   function automatic logic is_cross(input logic [2:0] o, input logic [1:0] sz);
      return (4'(o) + (4'd1 << sz)) > 4'd8;
   endfunction

   // Right-align the addressed bytes of {hi,lo}, truncate to the access size and extend.
   function automatic logic [63:0] extract(input logic [127:0] pair, input logic [2:0] o,
                                           input logic [1:0] sz, input logic uns);
      logic [63:0] s;
      logic [63:0] r;
      s = 64'(pair >> {o, 3'b000});
      unique case (sz)
         2'd0:    r = {{56{~uns & s[7]}},  s[7:0]};
         2'd1:    r = {{48{~uns & s[15]}}, s[15:0]};
         2'd2:    r = {{32{~uns & s[31]}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   assign off   = addr_q[2:0];
   assign nmask = 8'((9'd1 << (4'd1 << size_q)) - 9'd1);
   assign beat0 = (state_q == S_BEAT0) & ~rst;
   assign base  = {addr_q[63:3], 3'b000};

`ifdef LSU_SPLIT_MISALIGN_EN
   logic              beat1;
   logic              cross_q;
   logic [15:0]       lanes;
   logic [127:0]      wide;

   assign beat1   = (state_q == S_BEAT1) & ~rst;
   assign cross_q = is_cross(off, size_q);
   assign lanes   = 16'(nmask) << off;
   assign wide    = 128'(wdata_q) << {off, 3'b000};
`else
   logic [LANES-1:0]  lanes;
   logic [XLEN-1:0]   wide;

   assign lanes = nmask << off;
   assign wide  = wdata_q << {off, 3'b000};
`endif

   // Memory port decode; idle and reset cycles drive all zeros.
   always_comb begin
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (beat0) begin
         mem_ce   = 1'b1;
         mem_we   = we_q;
         mem_addr = base;
         if (we_q) begin
            mem_wmask = lanes[7:0];
            mem_wdata = wide[63:0];
         end
      end
`ifdef LSU_SPLIT_MISALIGN_EN
      if (beat1) begin
         mem_ce   = 1'b1;
         mem_we   = we_q;
         mem_addr = base + 64'd8;
         if (we_q) begin
            mem_wmask = lanes[15:8];
            mem_wdata = wide[127:64];
         end
      end
`endif
   end

   assign req_ready = (state_q == S_IDLE) & ~rst;
   assign rsp_valid = (state_q == S_RESP) & ~rst;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef LSU_SPLIT_MISALIGN_EN
      lo_d    = lo_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = S_BEAT0;
`ifndef LSU_SPLIT_MISALIGN_EN
               if (is_cross(req_addr[2:0], req_size)) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
`endif
            end
         end
         S_BEAT0: begin
`ifdef LSU_SPLIT_MISALIGN_EN
            if (!we_q) lo_d = mem_rdata;
            if (cross_q) begin
               state_d = S_BEAT1;
            end else begin
               rdata_d = we_q ? '0 : extract({64'd0, mem_rdata}, off, size_q, uns_q);
               state_d = S_RESP;
            end
`else
            rdata_d = we_q ? '0 : extract({64'd0, mem_rdata}, off, size_q, uns_q);
            state_d = S_RESP;
`endif
         end
`ifdef LSU_SPLIT_MISALIGN_EN
         S_BEAT1: begin
            // Second beat supplies the high half directly; only lo needs holding.
            rdata_d = we_q ? '0 : extract({mem_rdata, lo_q}, off, size_q, uns_q);
            state_d = S_RESP;
         end
`endif
         S_RESP: begin
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef LSU_SPLIT_MISALIGN_EN
         lo_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef LSU_SPLIT_MISALIGN_EN
         lo_q    <= lo_d;
`endif
      end
   end

endmodule

// File: doc/lsu_mem_req.md
# lsu_mem_req

Load/store initiator between the execute stage and the DPI-backed data-memory responder. It accepts one load or store per valid/ready handshake and converts byte/half/word/double accesses into 8-byte-aligned memory beats with byte masks. For loads, it extracts and sign- or zero-extends the result. The result is returned on a valid/ready response channel. It is the requesting end of the memory port (ce/we/addr/wdata/wmask/rdata).

## Interface
Parameters: none.

- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D
- req_unsigned  in  1  zero-extend load (ignored for D and stores)
- req_wdata  in  64  store data, right-aligned
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  64  extended load data; 0 for stores and errors
- rsp_err  out  1  access rejected
- mem_ce  out  1  beat strobe, exactly one cycle per beat
- mem_we  out  1  beat is a write
- mem_addr  out  64  8-byte-aligned beat address
- mem_wdata  out  64  lane-shifted write data
- mem_wmask  out  8  byte enables, bit i = byte lane i
- mem_rdata  in  64  read data, valid combinationally in the same cycle as mem_ce&~mem_we

## Operation
- Request fields are captured on acceptance. All mem_* outputs derive only from the state and captured registers. There is no combinational path from req_* to mem_*.
- Definitions: off = addr[2:0], n = 1<<size, cross = off+n > 8.
- **IDLE:** req_ready = ~rst. On accept, go to BEAT0. If cross and split is compiled out, go to RESP with err set instead.
- **BEAT0:**
  - mem_ce = 1, mem_addr = {addr[63:3],3'b0}.
  - mem_wmask = (((1<<n)-1) << off)[7:0].
  - mem_wdata = wdata << 8*off.
  - Load: latch mem_rdata into lo.
  - Next state: BEAT1 if cross, else RESP.
- **BEAT1** (split only):
  - mem_ce = 1, mem_addr = base + 8.
  - mem_wmask = ((1<<n)-1) >> (8-off).
  - mem_wdata = wdata >> 8*(8-off).
  - Load: latch mem_rdata into hi.
  - Next state: RESP.
- **RESP:**
  - rsp_valid = 1.
  - rsp_rdata = ({hi,lo} >> 8*off), truncated to n bytes, then sign-extended unless unsigned or size = 3.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready; then go to IDLE.
- Outside the BEAT states: mem_ce = mem_we = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0.
- Non-crossing misaligned accesses (e.g. H at off = 1) are legal and need a single beat.

## Timing
- Accept at cycle 0. BEAT0 at cycle 1. rsp_valid at cycle 2, or cycle 3 when split. The error response appears at cycle 1 with no mem_ce.
- Response and next request are not overlapped: req_ready = 0 from acceptance until the RESP handshake completes. req_ready returns high the cycle after rsp_valid&rsp_ready.
- **Reset:**
  - On the first rst cycle, mem_ce, mem_we, req_ready and rsp_valid are forced 0.
  - After the edge, state is IDLE and all outputs and registers are 0; req_ready is 1 once rst deasserts.
  - Reset during BEAT1 abandons the access. A BEAT0 store already performed is not undone. No response is produced.
- req_valid asserted while busy is ignored; it is not captured.

## Configuration
- **LSU_SPLIT_MISALIGN_EN defined:** crossing accesses use two beats (BEAT0, BEAT1). rsp_err is always 0.
- **LSU_SPLIT_MISALIGN_EN undefined:**
  - BEAT1 logic and the hi register are absent.
  - A crossing access produces no memory beat and goes directly to RESP with rsp_err = 1 and rsp_rdata = 0.
  - Non-crossing accesses behave identically in both builds.

## Test plan
- **Reset:** hold rst for 2 cycles with req_valid = 1 -> all outputs 0 throughout, nothing captured; req_ready = 1 the cycle after rst falls.
- **Signed byte load:** LB at 0x80000003, mem_rdata = 0x0000000080000000 -> mem_addr 0x80000000, mem_wmask 0x00; rsp_rdata 0xFFFFFFFFFFFFFF80 at cycle 2. The same access with req_unsigned = 1 gives 0x80.
- **Word store:** SW at 0x80000004, wdata 0x1122334455667788 -> one mem_ce cycle, mem_we 1, mem_wmask 0xF0, mem_wdata 0x5566778800000000; response rdata 0, err 0.
- **Crossing double load:** LD at 0x80000006.
  - Split on, lo = 0xAABB000000000000, hi = 0x0000112233445566 -> beats at 0x80000000 and 0x80000008; rsp_rdata 0x112233445566AABB at cycle 3.
  - Split on, SD at the same address -> masks 0xC0 then 0x3F.
  - Split off -> rsp_err 1 at cycle 1, mem_ce never asserted.
- **Backpressure:** rsp_ready low for 3 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err held, req_ready 0, mem_ce 0, a concurrent req_valid ignored. The handshake completes in cycle 4 and req_ready = 1 the following cycle.
- **Reset mid-access:** rst asserted during BEAT1 -> mem_ce 0 that cycle, IDLE next cycle, rsp_valid never asserted.
